// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the decode-side hazard logic of the ARM-subset core:
// register index width, number of architectural registers that are tracked,
// the PC index (never tracked), and the width of each scoreboard counter.
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int REG_IDX_W     = 4;
    localparam int NUM_ARCH_REGS = 15;
    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

    // Width of each per-register in-flight counter
    localparam int SB_CNT_W = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // R15 is the PC: it is written by the fetch logic, not through WB,
    // so it never takes part in hazard tracking.
    function automatic logic isTracked(input reg_idx_t idx);
        return idx != PC_IDX;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_if
// Groups the ID issue request, the WB retire port and the scoreboard results.
//   master : core side   (drives id_* / wb_*, receives stall/issue/pending/err)
//   slave  : scoreboard  (receives id_* / wb_*, drives stall/issue/pending/err)
// Signals:
//   id_valid, id_flush, id_src1, id_src2, id_two_src, id_wb_en, id_dest
//   wb_en, wb_dest
//   stall, issue, pending[14:0], overflow_err
// -----------------------------------------------------------------------------
interface reg_scoreboard_if;
    import core_pkg::*;

    logic                      id_valid;
    logic                      id_flush;
    reg_idx_t                  id_src1;
    reg_idx_t                  id_src2;
    logic                      id_two_src;
    logic                      id_wb_en;
    reg_idx_t                  id_dest;
    logic                      wb_en;
    reg_idx_t                  wb_dest;
    logic                      stall;
    logic                      issue;
    logic [NUM_ARCH_REGS-1:0]  pending;
    logic                      overflow_err;

    modport master (
        output id_valid, id_flush, id_src1, id_src2, id_two_src, id_wb_en,
               id_dest, wb_en, wb_dest,
        input  stall, issue, pending, overflow_err
    );

    modport slave (
        input  id_valid, id_flush, id_src1, id_src2, id_two_src, id_wb_en,
               id_dest, wb_en, wb_dest,
        output stall, issue, pending, overflow_err
    );

endinterface

// File: rtl/sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// One in-flight write counter for a single architectural register.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_inc          a writer of this register issues this cycle
//   i_dec          a write to this register retires this cycle
//   o_cnt          current count
//   o_nonzero      count is not zero (registered-state derived)
//   o_underflow    a retire arrived while the count was zero (combinational)
// -----------------------------------------------------------------------------
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_nonzero,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;

    // A retire with nothing in flight means the core lost track of a write;
    // the count is held at zero and the event is reported to the parent.
    assign o_underflow = i_dec && !i_inc && (r_cnt == '0);

    // Simultaneous issue and retire cancel out. Increment cannot wrap because
    // the parent stalls any writer that would push the count past its max.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_nonzero = (r_cnt != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Decode-side hazard tracker in front of the register file read ports.
// Each destination claimed by an issued instruction bumps that register's
// in-flight counter; each WB write drops it. ID is stalled while any source
// it reads still has a write in flight, or while its destination counter is
// already full.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sb         reg_scoreboard_if.slave (ID request, WB retire, results)
// -----------------------------------------------------------------------------
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int CNT_W    = SB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    reg_scoreboard_if.slave   sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    w_cnt      [NUM_REGS];
    logic [CNT_W-1:0]    w_effCnt   [16];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_nonzero;
    logic [NUM_REGS-1:0] w_underflow;
    logic                w_hz1;
    logic                w_hz2;
    logic                w_sat;
    logic                w_stall;
    logic                w_issue;
    logic                r_overflowErr;

    // The register file writes on negedge, so a register retiring this cycle
    // is already readable by ID: discount that retire before checking hazards.
    // Entry 15 (PC) stays zero so a PC index can be looked up without a guard.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_effCnt[i] = '0;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            w_effCnt[i] = w_cnt[i] - CNT_W'(w_dec[i] && (w_cnt[i] != '0));
        end
    end

    assign w_hz1   = isTracked(sb.id_src1) && (w_effCnt[sb.id_src1] != '0);
    assign w_hz2   = sb.id_two_src && isTracked(sb.id_src2)
                     && (w_effCnt[sb.id_src2] != '0);
    assign w_sat   = sb.id_wb_en && isTracked(sb.id_dest)
                     && (w_effCnt[sb.id_dest] == CNT_MAX);
    assign w_stall = sb.id_valid && !sb.id_flush && (w_hz1 || w_hz2 || w_sat);
    assign w_issue = sb.id_valid && !sb.id_flush && !w_stall;

    // One counter per tracked register; index 15 never matches any of them,
    // so PC writes and retires are ignored automatically.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        assign w_inc[g] = w_issue && sb.id_wb_en && (sb.id_dest == REG_IDX_W'(g));
        assign w_dec[g] = sb.wb_en && (sb.wb_dest == REG_IDX_W'(g));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc[g]),
            .i_dec       (w_dec[g]),
            .o_cnt       (w_cnt[g]),
            .o_nonzero   (w_nonzero[g]),
            .o_underflow (w_underflow[g])
        );
    end

    // Sticky error: once any retire hits an empty counter, it stays flagged
    // until reset so software/debug can see it happened.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflowErr <= 1'b0;
        end else if (|w_underflow) begin
            r_overflowErr <= 1'b1;
        end
    end

    assign sb.stall        = w_stall;
    assign sb.issue        = w_issue;
    assign sb.pending      = w_nonzero;
    assign sb.overflow_err = r_overflowErr;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Decode-side hazard tracker that sits directly upstream of the register file read ports in the pipelined ARM-subset core.
- Records each destination register claimed by an instruction issued from ID, and clears the claim when that write retires through the WB write port.
- Raises stall whenever an ID source operand still has a write in flight.
- Replaces ad-hoc EXE/MEM destination comparison with per-register in-flight counters.

Parameters:
- NUM_REGS, 15, number of tracked architectural registers (R0..R14); index 15 (PC) is never tracked.
- CNT_W, 2, width of each per-register in-flight counter; max count is 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction this cycle.
- id_flush  input  1  branch flush; instruction in ID must not be issued.
- id_src1  input  4  first source register index (same value driven to the register file src1).
- id_src2  input  4  second source register index.
- id_two_src  input  1  instruction reads id_src2.
- id_wb_en  input  1  instruction writes a destination register.
- id_dest  input  4  destination register index.
- wb_en  input  1  WB write this cycle (same signal as the register file writeBackEn).
- wb_dest  input  4  WB destination (same signal as the register file dest_wb).
- stall  output  1  combinational; freezes IF/ID and inserts a bubble into ID/EXE.
- issue  output  1  combinational; the instruction in ID advances this cycle.
- pending  output  15  registered; bit i = counter i nonzero.
- overflow_err  output  1  sticky; set if a retire hits a zero counter.

Behaviour:
- Reset (rst=1 at posedge):
  - all counters 0, pending=0, overflow_err=0.
  - stall and issue evaluate from the cleared state.
  - Reset overrides any same-cycle issue or retire.
- Retire bypass:
  - The register file writes on negedge, so an ID read in the same cycle as the WB write sees the new value.
  - eff_cnt[i] = cnt[i] - (wb_en && wb_dest==i && i<15 && cnt[i]!=0).
- Hazard:
  - hz1 = id_src1<15 && eff_cnt[id_src1]!=0.
  - hz2 = id_two_src && id_src2<15 && eff_cnt[id_src2]!=0.
- Saturation: sat = id_wb_en && id_dest<15 && eff_cnt[id_dest]==max.
- stall = id_valid && !id_flush && (hz1 || hz2 || sat).
- issue = id_valid && !id_flush && !stall.
- Counter update per register i at posedge (not rst):
  - inc_i = issue && id_wb_en && id_dest==i && i<15.
  - dec_i = wb_en && wb_dest==i && i<15.
  - inc and dec together: counter unchanged.
  - inc only: +1 (cannot exceed max, guaranteed by sat).
  - dec only: -1 if nonzero. If zero, hold at 0 and set overflow_err.
- Index 15 is ignored for sources, destination and retire; it never stalls.
- pending[i] reflects the registered counters, updated one cycle after the issue/retire edge.
- Flush:
  - Kills only the ID instruction (no increment).
  - Instructions already issued still retire or are squashed downstream.
  - Squashed instructions must drive wb_en=0 but are still counted. The core therefore only flushes instructions that never issued; EXE/MEM writes must not be squashed after issue.
- Stall never blocks retire, so progress is guaranteed.

Decomposition:
- Shared package core_pkg:
  - REG_IDX_W=4, NUM_ARCH_REGS=15, PC_IDX=4'd15.
  - Scoreboard counter width constant.
- One natural sub-module: sb_counter. It is a single CNT_W up/down counter with simultaneous inc/dec, an underflow flag and a nonzero output, instantiated NUM_REGS times via generate.

Test Plan:
- Reset then idle: pending=0, stall=0, overflow_err=0. Issue writing R3 (id_valid=1, id_wb_en=1, id_dest=3): issue=1, pending=0x0008 next cycle.
- R3 pending, next instruction has id_src1=3: stall=1, issue=0 each cycle. Assert wb_en=1, wb_dest=3 → stall=0 and issue=1 in that same cycle, pending[3]=0 after the edge.
- Three back-to-back writes to R5 with no retire: counter=3. A fourth writer of R5 with unrelated sources → stall=1 (sat). A single retire of R5 → stall releases the same cycle and the counter stays 3.
- Same cycle: issue writing R7 and retire of R7 with count 1 → count stays 1, pending[7]=1.
- id_src2=4 pending with id_two_src=0 → stall=0. id_src1=15 and id_dest=15 → never stall, pending unchanged. id_flush=1 with a valid writer → issue=0, no increment.
- wb_en=1, wb_dest=9 with count 0 → overflow_err=1 and stays set. A mid-sequence rst with counters nonzero clears all state at the next posedge.
